// File: rtl/hood_timer_scheduler.sv
// rtl/hood_timer_scheduler.sv - shared seconds countdown for the range-hood mode controller
// Arbitrates exit/self-clean load requests, derives the 1 Hz tick and keeps binary and BCD remain in lockstep.
module hood_timer_scheduler #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int EXIT_SEC      = 60,
  parameter int CLEAN_SEC     = 180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_exit,
  input  logic        req_clean,
  input  logic        pause,
  input  logic        cancel,
  output logic        busy,
  output logic [1:0]  owner,
  output logic        grant,
  output logic        sec_tick,
  output logic [7:0]  remain_sec,
  output logic [11:0] remain_bcd,
  output logic        done,
  output logic [1:0]  done_owner,
  output logic        aborted
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]  EXIT_BIN  = 8'(EXIT_SEC);
  localparam logic [7:0]  CLEAN_BIN = 8'(CLEAN_SEC);
  localparam logic [11:0] EXIT_BCD  =
    12'((EXIT_SEC / 100) * 256 + ((EXIT_SEC / 10) % 10) * 16 + (EXIT_SEC % 10));
  localparam logic [11:0] CLEAN_BCD =
    12'((CLEAN_SEC / 100) * 256 + ((CLEAN_SEC / 10) % 10) * 16 + (CLEAN_SEC % 10));
  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_EXIT  = 2'b01;
  localparam logic [1:0] OWN_CLEAN = 2'b10;

  // S_FIN is the single cycle that shows done while busy/owner are still held.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_FIN} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic [7:0]      sec_nxt;
  logic [11:0]     bcd_nxt;
  logic [1:0]      owner_nxt, done_owner_nxt;
  logic            grant_nxt, tick_nxt, done_nxt, aborted_nxt;
  logic            active, load, load_clean;

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4]  = 4'd9;
        r[11:8] = v[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    presc_nxt      = presc;
    sec_nxt        = remain_sec;
    bcd_nxt        = remain_bcd;
    owner_nxt      = owner;
    done_owner_nxt = done_owner;
    grant_nxt      = 1'b0;
    tick_nxt       = 1'b0;
    done_nxt       = 1'b0;
    aborted_nxt    = 1'b0;
    load           = 1'b0;
    load_clean     = 1'b0;
    active         = (state == S_RUN) || (state == S_PAUSE);

    if (state == S_FIN) begin
      state_nxt = S_IDLE;
      owner_nxt = OWN_NONE;
    end

    if (cancel) begin
      if (active) begin
        state_nxt   = S_IDLE;
        presc_nxt   = '0;
        sec_nxt     = 8'd0;
        bcd_nxt     = 12'h000;
        owner_nxt   = OWN_NONE;
        aborted_nxt = 1'b1;
      end
    end else if (req_clean) begin
      load        = 1'b1;
      load_clean  = 1'b1;
      aborted_nxt = active && (owner == OWN_EXIT);
    end else if (req_exit && !(active && (owner == OWN_CLEAN))) begin
      load = 1'b1;
    end else if (active) begin
      if (pause) begin
        state_nxt = S_PAUSE;
      end else begin
        state_nxt = S_RUN;
        if (presc == PRESC_LAST) begin
          presc_nxt = '0;
          tick_nxt  = 1'b1;
          sec_nxt   = remain_sec - 8'd1;
          bcd_nxt   = bcd_dec(remain_bcd);
          if (remain_sec == 8'd1) begin
            done_nxt       = 1'b1;
            done_owner_nxt = owner;
            state_nxt      = S_FIN;
          end
        end else begin
          presc_nxt = presc + PW'(1);
        end
      end
    end

    if (load) begin
      state_nxt = S_RUN;
      presc_nxt = '0;
      grant_nxt = 1'b1;
      owner_nxt = load_clean ? OWN_CLEAN : OWN_EXIT;
      sec_nxt   = load_clean ? CLEAN_BIN : EXIT_BIN;
      bcd_nxt   = load_clean ? CLEAN_BCD : EXIT_BCD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      remain_sec <= 8'd0;
      remain_bcd <= 12'h000;
      owner      <= OWN_NONE;
      done_owner <= OWN_NONE;
      grant      <= 1'b0;
      sec_tick   <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      presc      <= presc_nxt;
      remain_sec <= sec_nxt;
      remain_bcd <= bcd_nxt;
      owner      <= owner_nxt;
      done_owner <= done_owner_nxt;
      grant      <= grant_nxt;
      sec_tick   <= tick_nxt;
      done       <= done_nxt;
      aborted    <= aborted_nxt;
    end
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_hood_timer_scheduler.sv
// tb/tb_hood_timer_scheduler.sv - directed bench for hood_timer_scheduler
module tb_hood_timer_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_exit, req_clean, pause, cancel;
  logic        busy, grant, sec_tick, done, aborted;
  logic [1:0]  owner, done_owner;
  logic [7:0]  remain_sec;
  logic [11:0] remain_bcd;

  int total = 0;
  int bad   = 0;

  hood_timer_scheduler #(.TICKS_PER_SEC(4), .EXIT_SEC(3), .CLEAN_SEC(180)) dut (
    .clk(clk), .reset(reset), .req_exit(req_exit), .req_clean(req_clean),
    .pause(pause), .cancel(cancel), .busy(busy), .owner(owner), .grant(grant),
    .sec_tick(sec_tick), .remain_sec(remain_sec), .remain_bcd(remain_bcd),
    .done(done), .done_owner(done_owner), .aborted(aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rx, rc, pz, cn;
    logic       busy;
    logic [1:0] own;
    logic       gr, tk;
    logic [7:0] rem;
    logic       dn;
    logic [1:0] dow;
    logic       ab;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t v(input logic rx, input logic rc, input logic pz, input logic cn,
                             input logic b, input logic [1:0] own, input logic gr,
                             input logic tk, input logic [7:0] rem, input logic dn,
                             input logic [1:0] dow, input logic ab);
    vec_t r;
    r.rx = rx; r.rc = rc; r.pz = pz; r.cn = cn;
    r.busy = b; r.own = own; r.gr = gr; r.tk = tk; r.rem = rem;
    r.dn = dn; r.dow = dow; r.ab = ab;
    return r;
  endfunction

  function automatic logic [11:0] to_bcd(input logic [7:0] b);
    return {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_exit = 0; req_clean = 0; pause = 0; cancel = 0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    int errs;
    // rx rc pz cn | busy own gr tk rem dn dow ab
    tbl[0]  = v(1,0,0,0, 1,2'd1,1,0,8'd3,0,2'd0,0);
    tbl[1]  = v(0,0,0,0, 1,2'd1,0,0,8'd3,0,2'd0,0);
    tbl[2]  = v(0,0,0,0, 1,2'd1,0,0,8'd3,0,2'd0,0);
    tbl[3]  = v(0,0,0,0, 1,2'd1,0,0,8'd3,0,2'd0,0);
    tbl[4]  = v(0,0,0,0, 1,2'd1,0,1,8'd2,0,2'd0,0);
    tbl[5]  = v(0,0,0,0, 1,2'd1,0,0,8'd2,0,2'd0,0);
    tbl[6]  = v(0,0,0,0, 1,2'd1,0,0,8'd2,0,2'd0,0);
    tbl[7]  = v(0,0,0,0, 1,2'd1,0,0,8'd2,0,2'd0,0);
    tbl[8]  = v(0,0,0,0, 1,2'd1,0,1,8'd1,0,2'd0,0);
    tbl[9]  = v(0,0,0,0, 1,2'd1,0,0,8'd1,0,2'd0,0);
    tbl[10] = v(0,0,0,0, 1,2'd1,0,0,8'd1,0,2'd0,0);
    tbl[11] = v(0,0,0,0, 1,2'd1,0,0,8'd1,0,2'd0,0);
    tbl[12] = v(0,0,0,0, 1,2'd1,0,1,8'd0,1,2'd1,0);
    tbl[13] = v(0,0,0,0, 0,2'd0,0,0,8'd0,0,2'd1,0);
    tbl[14] = v(1,0,0,0, 1,2'd1,1,0,8'd3,0,2'd1,0);
    tbl[15] = v(0,0,0,0, 1,2'd1,0,0,8'd3,0,2'd1,0);
    tbl[16] = v(0,0,0,0, 1,2'd1,0,0,8'd3,0,2'd1,0);
    tbl[17] = v(0,0,0,0, 1,2'd1,0,0,8'd3,0,2'd1,0);
    tbl[18] = v(0,0,0,0, 1,2'd1,0,1,8'd2,0,2'd1,0);
    tbl[19] = v(0,0,0,0, 1,2'd1,0,0,8'd2,0,2'd1,0);
    tbl[20] = v(0,0,0,0, 1,2'd1,0,0,8'd2,0,2'd1,0);
    tbl[21] = v(0,0,0,0, 1,2'd1,0,0,8'd2,0,2'd1,0);
    tbl[22] = v(0,0,0,0, 1,2'd1,0,1,8'd1,0,2'd1,0);
    tbl[23] = v(0,0,0,0, 1,2'd1,0,0,8'd1,0,2'd1,0);
    tbl[24] = v(0,0,0,0, 1,2'd1,0,0,8'd1,0,2'd1,0);
    tbl[25] = v(0,0,0,0, 1,2'd1,0,0,8'd1,0,2'd1,0);
    // request lands on the expiry-tick cycle: reload wins, no done
    tbl[26] = v(1,0,0,0, 1,2'd1,1,0,8'd3,0,2'd1,0);
    tbl[27] = v(0,0,0,0, 1,2'd1,0,0,8'd3,0,2'd1,0);

    do_reset();
    chk("rst.busy", busy, 0);
    chk("rst.owner", owner, 0);
    chk("rst.remain", remain_sec, 0);
    chk("rst.bcd", remain_bcd, 0);
    chk("rst.pulses", {grant, sec_tick, done, aborted}, 0);
    chk("rst.done_owner", done_owner, 0);

    for (int i = 0; i < 28; i++) begin
      req_exit = tbl[i].rx; req_clean = tbl[i].rc; pause = tbl[i].pz; cancel = tbl[i].cn;
      cyc();
      req_exit = 0; req_clean = 0; pause = 0; cancel = 0;
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d.owner", i), owner, tbl[i].own);
      chk($sformatf("vec%0d.grant", i), grant, tbl[i].gr);
      chk($sformatf("vec%0d.tick", i), sec_tick, tbl[i].tk);
      chk($sformatf("vec%0d.remain", i), remain_sec, tbl[i].rem);
      chk($sformatf("vec%0d.bcd", i), remain_bcd, to_bcd(tbl[i].rem));
      chk($sformatf("vec%0d.done", i), done, tbl[i].dn);
      chk($sformatf("vec%0d.done_owner", i), done_owner, tbl[i].dow);
      chk($sformatf("vec%0d.aborted", i), aborted, tbl[i].ab);
    end

    // clean pre-empts exit, then BCD borrow down to 99
    do_reset();
    req_exit = 1; cyc(); req_exit = 0;
    repeat (4) cyc();
    chk("pre.remain2", remain_sec, 2);
    req_clean = 1; cyc(); req_clean = 0;
    chk("pre.aborted", aborted, 1);
    chk("pre.grant", grant, 1);
    chk("pre.owner", owner, 2);
    chk("pre.remain", remain_sec, 180);
    chk("pre.bcd", remain_bcd, 12'h180);
    req_exit = 1; cyc(); req_exit = 0;
    chk("ign.grant", grant, 0);
    chk("ign.owner", owner, 2);
    chk("ign.remain", remain_sec, 180);
    chk("ign.aborted", aborted, 0);
    cyc(); cyc();
    chk("pre.tick_early", sec_tick, 0);
    cyc();
    chk("pre.tick_at4", sec_tick, 1);
    chk("pre.bcd179", remain_bcd, 12'h179);
    errs = 0;
    for (int i = 0; i < 320; i++) begin
      cyc();
      if (remain_bcd !== to_bcd(remain_sec)) errs++;
    end
    chk("bcd.track_errs", errs, 0);
    chk("bcd.tick81", sec_tick, 1);
    chk("bcd.remain99", remain_sec, 99);
    chk("bcd.bcd099", remain_bcd, 12'h099);

    cancel = 1; req_clean = 1; cyc(); cancel = 0; req_clean = 0;
    chk("can.busy", busy, 0);
    chk("can.aborted", aborted, 1);
    chk("can.grant", grant, 0);
    chk("can.owner", owner, 0);
    chk("can.remain", remain_sec, 0);
    chk("can.done", done, 0);
    cancel = 1; cyc(); cancel = 0;
    chk("can_idle.aborted", aborted, 0);

    // pause for 10 cycles pushes the first tick from +4 to +14
    do_reset();
    req_exit = 1; cyc(); req_exit = 0;
    cyc();
    pause = 1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (busy !== 1'b1 || remain_sec !== 8'd3 || sec_tick !== 1'b0) errs++;
    end
    pause = 0;
    chk("pause.frozen_errs", errs, 0);
    cyc(); cyc();
    chk("pause.tick_g13", sec_tick, 0);
    cyc();
    chk("pause.tick_g14", sec_tick, 1);
    chk("pause.remain", remain_sec, 2);

    // asynchronous reset mid-count
    do_reset();
    req_exit = 1; cyc(); req_exit = 0;
    repeat (4) cyc();
    chk("arst.pre_remain", remain_sec, 2);
    #3 reset = 1'b0;
    #1;
    chk("arst.outputs", {busy, owner, grant, sec_tick, remain_sec, remain_bcd, done, done_owner, aborted}, 0);
    cyc();
    reset = 1'b1;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) errs++;
    end
    chk("arst.quiet_errs", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
